// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter between two requesters sharing one register bank.
// Winner's address/data are captured at grant; the bank sees one cycle of
// data setup, a single one-hot enable strobe, then a four-phase ack.
`timescale 1ns/1ps

module reg_bank_write_arbiter #(
    parameter int NREG = 4,
    parameter int AW   = 2,
    parameter int W    = 8
) (
    input  logic            CK,
    input  logic            Reset,
    input  logic            ReqA,
    input  logic [AW-1:0]   AddrA,
    input  logic [W-1:0]    DataA,
    input  logic            ReqB,
    input  logic [AW-1:0]   AddrB,
    input  logic [W-1:0]    DataB,
    output logic            AckA,
    output logic            AckB,
    output logic [W-1:0]    WrData,
    output logic [NREG-1:0] WrEn,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state;
    logic          win_b;   // 1: current transaction belongs to B
    logic          last_b;  // 1: B was served last, so A wins a tie
    logic [AW-1:0] addr_q;  // latched target register index
    logic          pick_b;
    logic          take;

    // One-hot decode of a register index into a per-register enable vector
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Winner selection: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        pick_b = ReqB && (!ReqA || !last_b);
        take   = (state == IDLE) && (ReqA || ReqB);
    end

    // Address capture at grant; never reset, always written before it is used
    always_ff @(posedge CK) begin
        if (take) begin
            addr_q <= pick_b ? AddrB : AddrA;
        end
    end

    // Control FSM with registered Moore outputs; WrData is loaded at grant and then held
    always_ff @(posedge CK or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            win_b  <= 1'b0;
            last_b <= 1'b1;
            AckA   <= 1'b0;
            AckB   <= 1'b0;
            WrEn   <= '0;
            WrData <= '0;
            Busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state  <= GRANT;
                        win_b  <= pick_b;
                        WrData <= pick_b ? DataB : DataA;
                        Busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    // Data has been stable for a full cycle; fire the strobe next
                    state <= WRITE;
                    WrEn  <= onehot(addr_q);
                end
                WRITE: begin
                    state  <= ACK;
                    WrEn   <= '0;
                    last_b <= win_b;
                    if (win_b) begin
                        AckB <= 1'b1;
                    end else begin
                        AckA <= 1'b1;
                    end
                end
                ACK: begin
                    // Hold the ack until the winner withdraws its request
                    if (win_b ? !ReqB : !ReqA) begin
                        state <= IDLE;
                        AckA  <= 1'b0;
                        AckB  <= 1'b0;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Testbench for reg_bank_write_arbiter: directed vector table, hand-written
// corner sequences (alternation, reset mid-write), and a randomized run
// checked against a transaction-level arbitration model.
`timescale 1ns/1ps

module tb_reg_bank_write_arbiter;

    localparam int NREG = 4;
    localparam int AW   = 2;
    localparam int W    = 8;
    localparam int NRND = 2000;

    logic            CK = 1'b0;
    logic            Reset = 1'b0;
    logic            ReqA = 1'b0;
    logic [AW-1:0]   AddrA = '0;
    logic [W-1:0]    DataA = '0;
    logic            ReqB = 1'b0;
    logic [AW-1:0]   AddrB = '0;
    logic [W-1:0]    DataB = '0;
    logic            AckA;
    logic            AckB;
    logic [W-1:0]    WrData;
    logic [NREG-1:0] WrEn;
    logic            Busy;

    int checks = 0;
    int errors = 0;

    reg_bank_write_arbiter #(.NREG(NREG), .AW(AW), .W(W)) dut (
        .CK(CK), .Reset(Reset),
        .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA),
        .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB),
        .AckA(AckA), .AckB(AckB), .WrData(WrData), .WrEn(WrEn), .Busy(Busy)
    );

    always #5 CK = ~CK;

    // One comparison: counts it, reports a FAIL line on mismatch
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Directed vector: inputs driven this cycle, outputs expected this cycle
    typedef struct {
        logic            ra;
        logic [AW-1:0]   aa;
        logic [W-1:0]    da;
        logic            rb;
        logic [AW-1:0]   ab;
        logic [W-1:0]    db;
        logic [NREG-1:0] en;
        logic [W-1:0]    wd;
        logic            acka;
        logic            ackb;
        logic            busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ra, input logic [AW-1:0] aa, input logic [W-1:0] da,
                       input logic rb, input logic [AW-1:0] ab, input logic [W-1:0] db,
                       input logic [NREG-1:0] en, input logic [W-1:0] wd,
                       input logic acka, input logic ackb, input logic busy);
        vec_t v;
        v.ra = ra; v.aa = aa; v.da = da;
        v.rb = rb; v.ab = ab; v.db = db;
        v.en = en; v.wd = wd; v.acka = acka; v.ackb = ackb; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge CK); #1;
        Reset = 1'b0;
        ReqA = 1'b0; ReqB = 1'b0;
        @(posedge CK); #1;
        Reset = 1'b1;
    endtask

    // Input history of the random run, indexed by cycle
    logic          h_ra [NRND];
    logic          h_rb [NRND];
    logic [AW-1:0] h_aa [NRND];
    logic [AW-1:0] h_ab [NRND];
    logic [W-1:0]  h_da [NRND];
    logic [W-1:0]  h_db [NRND];

    // Reference-model state and helpers for the random run
    logic            m_last_b;
    logic            m_pick_b;
    logic [NREG-1:0] m_en;
    logic [W-1:0]    m_wd;
    logic [NREG-1:0] prev_en;
    int              ack_due_a, ack_due_b, writes_a, writes_b;
    int              wait_a, wait_b, gap_a, gap_b;
    int              order[$];
    int              budget, pulses, acks_seen, cnt_a;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Both request at once after reset (A wins), B then held 5 cycles in ACK,
        // then A alone with data changed after the grant
        //   ra aa  da     rb ab  db     en       wd     acka ackb busy
        add(1, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h00, 0, 0, 0);
        add(1, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h11, 0, 0, 1);
        add(1, 0, 8'h11, 1, 3, 8'h33, 4'b0001, 8'h11, 0, 0, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h11, 1, 0, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h11, 0, 0, 0);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 0, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b1000, 8'h33, 0, 0, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 1, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 0, 3, 8'h33, 4'b0000, 8'h33, 0, 1, 1);
        add(0, 0, 8'h11, 0, 3, 8'h33, 4'b0000, 8'h33, 0, 0, 0);
        add(1, 2, 8'h5A, 0, 0, 8'h00, 4'b0000, 8'h33, 0, 0, 0);
        add(1, 2, 8'hFF, 0, 0, 8'h00, 4'b0000, 8'h5A, 0, 0, 1);
        add(1, 2, 8'hFF, 0, 0, 8'h00, 4'b0100, 8'h5A, 0, 0, 1);
        add(0, 2, 8'hFF, 0, 0, 8'h00, 4'b0000, 8'h5A, 1, 0, 1);
        add(0, 2, 8'hFF, 0, 0, 8'h00, 4'b0000, 8'h5A, 0, 0, 0);

        Reset = 1'b0;
        repeat (2) @(posedge CK);
        #1 Reset = 1'b1;

        foreach (tbl[i]) begin
            @(posedge CK); #1;
            check($sformatf("row%0d WrEn", i),   WrEn,   tbl[i].en);
            check($sformatf("row%0d WrData", i), WrData, tbl[i].wd);
            check($sformatf("row%0d AckA", i),   AckA,   tbl[i].acka);
            check($sformatf("row%0d AckB", i),   AckB,   tbl[i].ackb);
            check($sformatf("row%0d Busy", i),   Busy,   tbl[i].busy);
            ReqA = tbl[i].ra; AddrA = tbl[i].aa; DataA = tbl[i].da;
            ReqB = tbl[i].rb; AddrB = tbl[i].ab; DataB = tbl[i].db;
        end

        // Continuous re-assertion: A was served last, so B goes first, then strict alternation
        AddrA = 2'd1; DataA = 8'hA1;
        AddrB = 2'd2; DataB = 8'hB2;
        ReqA = 1'b1; ReqB = 1'b1;
        budget = 0;
        while (order.size() < 8 && budget < 200) begin
            @(posedge CK); #1;
            budget++;
            if (WrEn == 4'b0010) order.push_back(0);
            else if (WrEn == 4'b0100) order.push_back(1);
            ReqA = !AckA;
            ReqB = !AckB;
        end
        ReqA = 1'b0; ReqB = 1'b0;
        check("alt count", order.size(), 8);
        cnt_a = 0;
        foreach (order[i]) begin
            check($sformatf("alt grant%0d", i), order[i], (i % 2 == 0) ? 1 : 0);
            if (order[i] == 0) cnt_a++;
        end
        check("alt writes A", cnt_a, 4);
        repeat (4) @(posedge CK);
        #1 check("alt idle after", Busy, 0);

        // Reset asserted during the WRITE cycle clears outputs without waiting for CK
        ReqA = 1'b1; AddrA = 2'd3; DataA = 8'hC3;
        budget = 0;
        do begin
            @(posedge CK); #1;
            budget++;
        end while (WrEn == 4'b0000 && budget < 10);
        check("rstw strobe", WrEn, 4'b1000);
        #1 Reset = 1'b0;
        #1;
        check("rstw WrEn async", WrEn, 4'b0000);
        check("rstw AckA async", AckA, 0);
        check("rstw Busy async", Busy, 0);
        check("rstw WrData async", WrData, 8'h00);
        #1 Reset = 1'b1;
        pulses = 0; acks_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CK); #1;
            if (WrEn != 4'b0000) begin
                pulses++;
                check("rstw reserve WrEn", WrEn, 4'b1000);
                check("rstw reserve WrData", WrData, 8'hC3);
            end
            if (AckA) begin
                acks_seen++;
                ReqA = 1'b0;
            end
        end
        check("rstw single pulse", pulses, 1);
        check("rstw ack count", acks_seen, 1);

        // Randomized run against the transaction-level model
        do_reset();
        m_last_b = 1'b1;
        ack_due_a = -1; ack_due_b = -1;
        writes_a = 0; writes_b = 0;
        wait_a = 0; wait_b = 0; gap_a = 0; gap_b = 0;
        prev_en = '0;
        for (int n = 0; n < NRND; n++) begin
            @(posedge CK); #1;
            if (WrEn != '0) begin
                check("rnd onehot", $onehot(WrEn), 1);
                check("rnd pulse width", prev_en, '0);
                if (n < 2 || !(h_ra[n-2] || h_rb[n-2])) begin
                    fail_now($sformatf("rnd spurious write at cycle %0d", n));
                end else begin
                    m_pick_b = h_rb[n-2] && (!h_ra[n-2] || !m_last_b);
                    m_en = NREG'(1) << (m_pick_b ? h_ab[n-2] : h_aa[n-2]);
                    m_wd = m_pick_b ? h_db[n-2] : h_da[n-2];
                    check("rnd WrEn", WrEn, m_en);
                    check("rnd WrData", WrData, m_wd);
                    m_last_b = m_pick_b;
                    if (m_pick_b) begin
                        ack_due_b = n + 1;
                        writes_b++;
                    end else begin
                        ack_due_a = n + 1;
                        writes_a++;
                    end
                end
            end
            check("rnd AckA", AckA, ack_due_a == n);
            check("rnd AckB", AckB, ack_due_b == n);
            prev_en = WrEn;

            if (ReqA) begin
                if (AckA) begin
                    ReqA = 1'b0; wait_a = 0; gap_a = $urandom_range(0, 2);
                end else begin
                    wait_a++;
                    if (wait_a > 40) begin
                        fail_now("rnd A starved");
                        ReqA = 1'b0; wait_a = 0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        AddrA = AW'($urandom); DataA = W'($urandom);
                    end
                end
            end else if (gap_a > 0) begin
                gap_a--;
            end else if ($urandom_range(0, 1) == 1) begin
                ReqA = 1'b1; AddrA = AW'($urandom); DataA = W'($urandom);
            end

            if (ReqB) begin
                if (AckB) begin
                    ReqB = 1'b0; wait_b = 0; gap_b = $urandom_range(0, 2);
                end else begin
                    wait_b++;
                    if (wait_b > 40) begin
                        fail_now("rnd B starved");
                        ReqB = 1'b0; wait_b = 0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        AddrB = AW'($urandom); DataB = W'($urandom);
                    end
                end
            end else if (gap_b > 0) begin
                gap_b--;
            end else if ($urandom_range(0, 1) == 1) begin
                ReqB = 1'b1; AddrB = AW'($urandom); DataB = W'($urandom);
            end

            h_ra[n] = ReqA; h_aa[n] = AddrA; h_da[n] = DataA;
            h_rb[n] = ReqB; h_ab[n] = AddrB; h_db[n] = DataB;
        end
        check("rnd A served", writes_a > 50, 1);
        check("rnd B served", writes_b > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
